// File: rtl/dmem_responder.sv
// dmem_responder: data-memory end of the core's load/store port.
// Accepts one request at a time (valid/ready). After LATENCY cycles it performs the
// access against an internal little-endian byte array, then holds the response
// until the consumer takes it.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   req_valid/ready  request handshake (ready = FSM idle)
//   req_we           1 = store, 0 = load
//   req_addr         byte address
//   req_wdata        right-aligned store data
//   req_size         00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned     zero-extend (1) or sign-extend (0) narrow loads
//   rsp_valid/ready  response handshake
//   rsp_rdata        load result, 0 for stores and faults
//   rsp_err          request faulted, no memory side effect
//   busy             transaction in flight (WAIT or RESP)
module dmem_responder #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_ADDR_BITS = 17,
    parameter int unsigned LATENCY       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int unsigned AW        = MEM_ADDR_BITS;
    localparam int unsigned MEM_BYTES = 1 << AW;
    // Counter holds LATENCY-1, which fits in clog2(LATENCY) bits (min 1 bit).
    localparam int unsigned CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned LANES     = DATA_WIDTH / 8;

    if (LATENCY < 1) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be >= 1");
    end
    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("dmem_responder: only DATA_WIDTH = 32 is supported");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [31:0]           addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [1:0]            size;
        logic                  uns;
    } req_t;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    req_t                  req_q, req_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [7:0]            mem_q [MEM_BYTES];

    logic [AW-1:0]         lane_addr_c [LANES];
    logic [7:0]            lane_byte_c [LANES];
    logic [LANES-1:0]      size_be_c;
    logic [LANES-1:0]      mem_be_c;
    logic                  acc_err_c;
    logic [DATA_WIDTH-1:0] load_data_c;

    // Address decode, fault check and little-endian load assembly for the latched request.
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            lane_addr_c[i] = req_q.addr[AW-1:0] + AW'(i);
            lane_byte_c[i] = mem_q[lane_addr_c[i]];
        end

        acc_err_c = (|req_q.addr[31:AW]);
        size_be_c = '0;
        unique case (req_q.size)
            2'b00: size_be_c = 4'b0001;
            2'b01: begin
                size_be_c = 4'b0011;
                if (req_q.addr[0]) acc_err_c = 1'b1;
            end
            2'b10: begin
                size_be_c = 4'b1111;
                if (req_q.addr[1:0] != 2'b00) acc_err_c = 1'b1;
            end
            default: acc_err_c = 1'b1;
        endcase

        unique case (req_q.size)
            2'b00: load_data_c = {{24{~req_q.uns & lane_byte_c[0][7]}}, lane_byte_c[0]};
            2'b01: load_data_c = {{16{~req_q.uns & lane_byte_c[1][7]}},
                                  lane_byte_c[1], lane_byte_c[0]};
            default: load_data_c = {lane_byte_c[3], lane_byte_c[2],
                                    lane_byte_c[1], lane_byte_c[0]};
        endcase
    end

    // Next-state and response logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_be_c = '0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_d.we    = req_we;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    req_d.size  = req_size;
                    req_d.uns   = req_unsigned;
                    cnt_d       = CW'(LATENCY - 1);
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    err_d   = acc_err_c;
                    rdata_d = (acc_err_c || req_q.we) ? '0 : load_data_c;
                    if (!acc_err_c && req_q.we) mem_be_c = size_be_c;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte array: not reset, written only on the execute edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (mem_be_c[i]) mem_q[lane_addr_c[i]] <= req_q.wdata[8*i +: 8];
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
